i2c_cfg_sequencer: RTL and testbench
====================================

Name: i2c_cfg_sequencer

Overview:
Parametrised register-init sequencer that walks a table of DEPTH write words and issues each one to a separate I2C master through a valid/ready command port. Used for codec, ADC/DAC and PLL bring-up.
Compared with the current fixed 12-entry codec init, it adds:
- re-triggerable start
- NACK retry with error reporting
- programmable inter-write gaps, including a long per-entry settle gap
- graceful abort
- progress index output
It sits between the top-level init control and the I2C master.

Parameters:
DEPTH, 12, number of table entries (1..256)
DATA_W, 16, bits per table entry/command word
DEV_ADDR, 7'b0011010, 7-bit I2C slave address driven on o_cmd_addr
GAP_CYCLES, 16, idle cycles between consecutive commands (>=1)
LONG_GAP_CYCLES, 1024, gap used after entries flagged in LONG_MASK (>=1)
LONG_MASK, 1 (entry 0), DEPTH-bit mask; bit k=1 selects the long gap after entry k
MAX_RETRY, 3, extra attempts per entry after a NACK (0 = no retry)
AUTO_START, 1, 1 = sequence starts automatically after reset release

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_start  in  1  pulse; (re)start sequence from entry 0 when in IDLE/DONE/ERROR
i_abort  in  1  pulse; stop after the in-flight command completes
i_table  in  DEPTH*DATA_W  entry k at [k*DATA_W +: DATA_W]
o_cmd_valid  out  1  command request to I2C master
i_cmd_ready  in  1  master accepts command when valid&ready
o_cmd_addr  out  7  = DEV_ADDR
o_cmd_data  out  DATA_W  current table entry
i_cmd_done  in  1  one-cycle pulse; transaction finished
i_cmd_nack  in  1  qualified by i_cmd_done; 1 = slave NACK
o_busy  out  1  high in ISSUE/WAIT/GAP
o_done  out  1  level; whole table written successfully
o_err  out  1  level; retries exhausted
o_idx  out  $clog2(DEPTH)  current/failing entry index

Behaviour:
- Reset (i_rst=1 at a clock edge) forces:
  - state=IDLE
  - idx=0, retry=0, gap counter=0, abort flag=0
  - all outputs 0
- Reset mid-transaction is immediate; the I2C master is reset by the same signal.
- AUTO_START=1: first cycle after reset, IDLE goes to ISSUE without i_start. AUTO_START=0: IDLE waits for i_start.
- States: IDLE, ISSUE, WAIT, GAP, DONE, ERROR.
- ISSUE:
  - o_cmd_valid=1; o_cmd_data=i_table[idx]; data held stable while valid.
  - On valid&ready, go to WAIT next cycle and drop valid.
  - Valid is not dropped before acceptance.
- WAIT: wait for i_cmd_done. On done:
  - nack=0 and idx==DEPTH-1: go to DONE.
  - nack=0 otherwise: idx++, retry=0, go to GAP.
  - nack=1 and retry<MAX_RETRY: retry++, idx unchanged, go to GAP.
  - nack=1 and retry==MAX_RETRY: go to ERROR; o_idx holds the failing entry.
- GAP:
  - Length is LONG_GAP_CYCLES if LONG_MASK bit of the just-completed entry is set, else GAP_CYCLES.
  - Exactly that many cycles are spent in GAP, then ISSUE.
  - Retry gaps always use GAP_CYCLES.
- Abort:
  - i_abort in ISSUE before acceptance: go to IDLE next cycle.
  - i_abort in WAIT: abort flag is set; on i_cmd_done go to IDLE (no done/err).
  - i_abort in GAP: go to IDLE.
  - In IDLE, abort suppresses AUTO_START re-entry.
- DONE/ERROR are sticky until i_start or reset. i_start there clears o_done/o_err, idx=0, retry=0, then ISSUE next cycle.
- i_start while busy is ignored.
- Simultaneous i_start and i_abort: abort wins.
- i_cmd_done outside WAIT is ignored.
- o_busy=1 exactly when state is ISSUE, WAIT or GAP.
- Minimum entry-to-entry latency with zero-latency master: ready on first ISSUE cycle, done one cycle later, then GAP_CYCLES.
- o_idx width is max(1,$clog2(DEPTH)).

Test Plan:
- Nominal: DEPTH=12, AUTO_START=1, master always ACKs, done 20 cycles after accept. Expect:
  - 12 commands with data=i_table[k] in order, o_cmd_addr=7'h1A
  - 1024-cycle gap after entry 0, 16-cycle gaps elsewhere
  - o_done=1, o_busy=0
- NACK recovery: NACK entry 5 twice, then ACK. Expect:
  - entry 5 issued 3 times, o_err=0
  - sequence completes, o_done=1
- Retry exhaustion: NACK entry 7 always, MAX_RETRY=3. Expect:
  - 4 attempts, then o_err=1, o_idx=7
  - no entry 8 issued
  - i_start then restarts at entry 0
- Backpressure: hold i_cmd_ready=0 for 50 cycles. Expect o_cmd_valid and o_cmd_data stable throughout, with exactly one accept.
- Abort in WAIT at entry 3. Expect:
  - no new command issued
  - IDLE after i_cmd_done
  - o_done=o_err=0, no auto restart
- Reset mid-GAP at entry 9, AUTO_START=0. Expect all outputs 0 and no command until i_start; i_start together with i_abort does not start.

Source files
------------

// File: rtl/i2c_cfg_sequencer.sv
// Register-init sequencer: walks a DEPTH-entry write table into an I2C master
// command port, with NACK retry, programmable gaps, abort and restart.
module i2c_cfg_sequencer #(
   parameter int               DEPTH           = 12,
   parameter int               DATA_W          = 16,
   parameter logic [6:0]       DEV_ADDR        = 7'b0011010,
   parameter int               GAP_CYCLES      = 16,
   parameter int               LONG_GAP_CYCLES = 1024,
   parameter logic [DEPTH-1:0] LONG_MASK       = DEPTH'(1),
   parameter int               MAX_RETRY       = 3,
   parameter bit               AUTO_START      = 1'b1,
   localparam int              IDX_W           = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_start,
   input  logic                    i_abort,
   input  logic [DEPTH*DATA_W-1:0] i_table,
   output logic                    o_cmd_valid,
   input  logic                    i_cmd_ready,
   output logic [6:0]              o_cmd_addr,
   output logic [DATA_W-1:0]       o_cmd_data,
   input  logic                    i_cmd_done,
   input  logic                    i_cmd_nack,
   output logic                    o_busy,
   output logic                    o_done,
   output logic                    o_err,
   output logic [IDX_W-1:0]        o_idx
);

   localparam int GAP_MAX = (LONG_GAP_CYCLES > GAP_CYCLES) ? LONG_GAP_CYCLES : GAP_CYCLES;
   localparam int GAP_W   = $clog2(GAP_MAX + 1);
   localparam int RTY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);
   localparam logic [GAP_W-1:0] GAP_SHORT = GAP_W'(GAP_CYCLES);
   localparam logic [GAP_W-1:0] GAP_LONG  = GAP_W'(LONG_GAP_CYCLES);
   localparam logic [RTY_W-1:0] RTY_MAX   = RTY_W'(MAX_RETRY);

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP, S_DONE, S_ERROR} state_t;

   state_t           state;
   logic [IDX_W-1:0] idx;
   logic [RTY_W-1:0] retry;
   logic [GAP_W-1:0] gap_cnt;
   logic             abort_flag;
   logic             auto_pend;

   function automatic logic [DATA_W-1:0] entry(input logic [DEPTH*DATA_W-1:0] tbl,
                                               input logic [IDX_W-1:0] k);
      return tbl[int'(k)*DATA_W +: DATA_W];
   endfunction

   // Address is only meaningful alongside a command, so it reads 0 otherwise.
   assign o_cmd_addr = o_cmd_valid ? DEV_ADDR : 7'd0;
   assign o_idx      = idx;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state       <= S_IDLE;
         idx         <= '0;
         retry       <= '0;
         gap_cnt     <= '0;
         abort_flag  <= 1'b0;
         auto_pend   <= AUTO_START;
         o_cmd_valid <= 1'b0;
         o_cmd_data  <= '0;
         o_busy      <= 1'b0;
         o_done      <= 1'b0;
         o_err       <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE, S_ERROR: begin
               // Abort wins over start and also cancels a pending auto-start.
               if (i_abort) begin
                  auto_pend <= 1'b0;
               end else if (i_start || (state == S_IDLE && auto_pend)) begin
                  state       <= S_ISSUE;
                  idx         <= '0;
                  retry       <= '0;
                  auto_pend   <= 1'b0;
                  o_cmd_valid <= 1'b1;
                  o_cmd_data  <= entry(i_table, '0);
                  o_busy      <= 1'b1;
                  o_done      <= 1'b0;
                  o_err       <= 1'b0;
               end
            end
            S_ISSUE: begin
               if (i_cmd_ready) begin
                  state       <= S_WAIT;
                  o_cmd_valid <= 1'b0;
                  abort_flag  <= i_abort;
               end else if (i_abort) begin
                  state       <= S_IDLE;
                  o_cmd_valid <= 1'b0;
                  o_busy      <= 1'b0;
               end
            end
            S_WAIT: begin
               if (i_cmd_done) begin
                  abort_flag <= 1'b0;
                  if (abort_flag || i_abort) begin
                     state  <= S_IDLE;
                     o_busy <= 1'b0;
                  end else if (!i_cmd_nack) begin
                     retry <= '0;
                     if (idx == LAST_IDX) begin
                        state  <= S_DONE;
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                     end else begin
                        idx     <= idx + 1'b1;
                        gap_cnt <= LONG_MASK[idx] ? GAP_LONG : GAP_SHORT;
                        state   <= S_GAP;
                     end
                  end else if (retry < RTY_MAX) begin
                     retry   <= retry + 1'b1;
                     gap_cnt <= GAP_SHORT;
                     state   <= S_GAP;
                  end else begin
                     state  <= S_ERROR;
                     o_busy <= 1'b0;
                     o_err  <= 1'b1;
                  end
               end else if (i_abort) begin
                  abort_flag <= 1'b1;
               end
            end
            S_GAP: begin
               if (i_abort) begin
                  state  <= S_IDLE;
                  o_busy <= 1'b0;
               end else if (gap_cnt == GAP_W'(1)) begin
                  state       <= S_ISSUE;
                  o_cmd_valid <= 1'b1;
                  o_cmd_data  <= entry(i_table, idx);
               end else begin
                  gap_cnt <= gap_cnt - 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Directed bench for i2c_cfg_sequencer: table-driven nominal sequence check plus
// NACK, retry exhaustion, backpressure, abort and reset sequences on two instances.
module tb_i2c_cfg_sequencer;

   localparam int DEPTH    = 12;
   localparam int DATA_W   = 16;
   localparam int IDX_W    = 4;
   localparam int DONE_LAT = 20;
   localparam logic [DATA_W-1:0] TBL [DEPTH] = '{
      16'h1A05, 16'h0217, 16'h0412, 16'h0679, 16'h0800, 16'h0A1F,
      16'h0C0D, 16'h0E33, 16'h1044, 16'h12C0, 16'h1455, 16'h1601};

   typedef struct {
      int                entry;
      logic [DATA_W-1:0] data;
      logic [6:0]        addr;
      int                delta;
   } vec_t;

   logic clk;
   logic [DEPTH*DATA_W-1:0] table_bus;

   logic rst_a, start_a, abort_a, valid_a, ready_a, done_a, nack_a, busy_a, dn_a, err_a;
   logic [6:0] addr_a;
   logic [DATA_W-1:0] data_a;
   logic [IDX_W-1:0] idx_a;

   logic rst_b, start_b, abort_b, valid_b, ready_b, done_b, nack_b, busy_b, dn_b, err_b;
   logic [6:0] addr_b;
   logic [DATA_W-1:0] data_b;
   logic [IDX_W-1:0] idx_b;

   int checks = 0;
   int errors = 0;

   i2c_cfg_sequencer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .AUTO_START(1'b1)) u_dut_a (
      .i_clk(clk), .i_rst(rst_a), .i_start(start_a), .i_abort(abort_a), .i_table(table_bus),
      .o_cmd_valid(valid_a), .i_cmd_ready(ready_a), .o_cmd_addr(addr_a), .o_cmd_data(data_a),
      .i_cmd_done(done_a), .i_cmd_nack(nack_a), .o_busy(busy_a), .o_done(dn_a), .o_err(err_a),
      .o_idx(idx_a));

   i2c_cfg_sequencer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .AUTO_START(1'b0)) u_dut_b (
      .i_clk(clk), .i_rst(rst_b), .i_start(start_b), .i_abort(abort_b), .i_table(table_bus),
      .o_cmd_valid(valid_b), .i_cmd_ready(ready_b), .o_cmd_addr(addr_b), .o_cmd_data(data_b),
      .i_cmd_done(done_b), .i_cmd_nack(nack_b), .o_busy(busy_b), .o_done(dn_b), .o_err(err_b),
      .o_idx(idx_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Master model for instance A: programmable stall, DONE_LAT response, NACK policy.
   int  stall_cnt  = 0;
   int  nack_entry = -1;
   int  nack_left  = 0;
   bit  m_pend;
   bit  m_nack;
   int  m_cnt;
   longint cyc;
   int                acc_idx [$];
   logic [DATA_W-1:0] acc_data[$];
   logic [6:0]        acc_addr[$];
   longint            acc_t   [$];

   initial begin
      ready_a = 1'b0; done_a = 1'b0; nack_a = 1'b0;
      m_pend = 1'b0; m_nack = 1'b0; m_cnt = 0; cyc = 0;
      forever begin
         @(posedge clk); #1;
         cyc++;
         done_a = 1'b0; nack_a = 1'b0;
         if (rst_a) m_pend = 1'b0;
         else if (m_pend) begin
            if (m_cnt == 0) begin
               done_a = 1'b1; nack_a = m_nack; m_pend = 1'b0;
            end else m_cnt--;
         end
         ready_a = (stall_cnt == 0);
         if (stall_cnt > 0) stall_cnt--;
         if (!rst_a && valid_a && ready_a) begin
            acc_idx.push_back(int'(idx_a));
            acc_data.push_back(data_a);
            acc_addr.push_back(addr_a);
            acc_t.push_back(cyc);
            m_pend = 1'b1;
            m_cnt  = DONE_LAT - 1;
            m_nack = (int'(idx_a) == nack_entry) && (nack_left > 0);
            if (m_nack) nack_left--;
         end
      end
   end

   // Zero-latency master for instance B: always ready, done one cycle after accept.
   bit b_pend;
   int b_acc;
   logic [DATA_W-1:0] b_last;

   initial begin
      ready_b = 1'b1; done_b = 1'b0; nack_b = 1'b0; b_pend = 1'b0; b_acc = 0; b_last = '0;
      forever begin
         @(posedge clk); #1;
         done_b = b_pend && !rst_b;
         b_pend = 1'b0;
         if (!rst_b && valid_b && ready_b) begin
            b_pend = 1'b1; b_acc++; b_last = data_b;
         end
      end
   end

   task automatic clear_log();
      acc_idx.delete(); acc_data.delete(); acc_addr.delete(); acc_t.delete();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vec [DEPTH];
      int   n, cnt, mx;
      bit   stable;
      int   acc0;

      rst_a = 1'b1; start_a = 1'b0; abort_a = 1'b0;
      rst_b = 1'b1; start_b = 1'b0; abort_b = 1'b0;
      for (int k = 0; k < DEPTH; k++) table_bus[k*DATA_W +: DATA_W] = TBL[k];
      // Accept-to-accept spacing: 20 done latency + 1 issue cycle + gap (1024 after entry 0).
      for (int k = 0; k < DEPTH; k++)
         vec[k] = '{entry: k, data: TBL[k], addr: 7'h1A, delta: (k == 0) ? 1045 : 37};

      repeat (3) @(negedge clk);
      chk("rst_valid", valid_a, 0); chk("rst_busy", busy_a, 0); chk("rst_done", dn_a, 0);
      chk("rst_err", err_a, 0); chk("rst_idx", idx_a, 0); chk("rst_data", data_a, 0);
      chk("rst_addr", addr_a, 0);

      // Nominal auto-started run
      rst_a = 1'b0;
      @(negedge clk);
      chk("auto_start_busy", busy_a, 1);
      chk("auto_start_valid", valid_a, 1);
      n = 0;
      while (!(dn_a || err_a) && n < 4000) begin @(negedge clk); n++; end
      chk("nom_timeout", n < 4000, 1);
      chk("nom_count", acc_idx.size(), DEPTH);
      for (int k = 0; k < acc_idx.size() && k < DEPTH; k++) begin
         chk($sformatf("nom_idx[%0d]", k), acc_idx[k], vec[k].entry);
         chk($sformatf("nom_data[%0d]", k), acc_data[k], vec[k].data);
         chk($sformatf("nom_addr[%0d]", k), acc_addr[k], vec[k].addr);
         if (k + 1 < acc_idx.size())
            chk($sformatf("nom_gap[%0d]", k), acc_t[k+1] - acc_t[k], vec[k].delta);
      end
      chk("nom_done", dn_a, 1); chk("nom_busy", busy_a, 0); chk("nom_err", err_a, 0);

      // NACK recovery: entry 5 NACKed twice
      clear_log(); nack_entry = 5; nack_left = 2;
      start_a = 1'b1; @(negedge clk); start_a = 1'b0;
      chk("restart_done_clr", dn_a, 0); chk("restart_busy", busy_a, 1);
      n = 0;
      while (!(dn_a || err_a) && n < 4000) begin @(negedge clk); n++; end
      chk("rec_timeout", n < 4000, 1);
      cnt = 0;
      foreach (acc_idx[i]) if (acc_idx[i] == 5) cnt++;
      chk("rec_entry5_attempts", cnt, 3);
      chk("rec_count", acc_idx.size(), 14);
      if (acc_idx.size() == 14) begin
         chk("rec_retry_gap", acc_t[6] - acc_t[5], 37);
         chk("rec_after5", acc_idx[8], 6);
      end
      chk("rec_done", dn_a, 1); chk("rec_err", err_a, 0);

      // Retry exhaustion at entry 7
      clear_log(); nack_entry = 7; nack_left = 1000;
      start_a = 1'b1; @(negedge clk); start_a = 1'b0;
      n = 0;
      while (!(dn_a || err_a) && n < 4000) begin @(negedge clk); n++; end
      chk("exh_timeout", n < 4000, 1);
      cnt = 0; mx = 0;
      foreach (acc_idx[i]) begin
         if (acc_idx[i] == 7) cnt++;
         if (acc_idx[i] > mx) mx = acc_idx[i];
      end
      chk("exh_attempts7", cnt, 4);
      chk("exh_max_idx", mx, 7);
      chk("exh_count", acc_idx.size(), 11);
      chk("exh_err", err_a, 1); chk("exh_done", dn_a, 0);
      chk("exh_idx", idx_a, 7); chk("exh_busy", busy_a, 0);
      repeat (40) @(negedge clk);
      chk("exh_sticky_err", err_a, 1);
      chk("exh_sticky_count", acc_idx.size(), 11);

      // Restart from ERROR under 50 cycles of backpressure
      clear_log(); nack_entry = -1; nack_left = 0; stall_cnt = 50;
      start_a = 1'b1; @(negedge clk); start_a = 1'b0;
      chk("bp_err_clr", err_a, 0); chk("bp_busy", busy_a, 1);
      stable = 1'b1;
      for (int i = 0; i < 50; i++) begin
         if (!(valid_a === 1'b1 && data_a === TBL[0] && acc_idx.size() == 0)) stable = 1'b0;
         @(negedge clk);
      end
      chk("bp_stable", stable, 1);
      n = 0;
      while (acc_idx.size() == 0 && n < 10) begin @(negedge clk); n++; end
      chk("bp_accept_timeout", n < 10, 1);
      repeat (3) @(negedge clk);
      chk("bp_one_accept", acc_idx.size(), 1);
      if (acc_idx.size() > 0) begin
         chk("bp_acc_idx", acc_idx[0], 0);
         chk("bp_acc_data", acc_data[0], TBL[0]);
      end
      chk("bp_valid_drop", valid_a, 0);

      // Abort while waiting on entry 3
      n = 0;
      while (acc_idx.size() < 4 && n < 2000) begin @(negedge clk); n++; end
      chk("abw_reach3", n < 2000, 1);
      @(negedge clk);
      abort_a = 1'b1; @(negedge clk); abort_a = 1'b0;
      chk("abw_still_busy", busy_a, 1);
      n = 0;
      while (busy_a && n < 100) begin @(negedge clk); n++; end
      chk("abw_timeout", n < 100, 1);
      chk("abw_after_done", m_pend, 0);
      repeat (100) @(negedge clk);
      chk("abw_no_new_cmd", acc_idx.size(), 4);
      chk("abw_busy", busy_a, 0); chk("abw_done", dn_a, 0); chk("abw_err", err_a, 0);
      chk("abw_valid", valid_a, 0);

      // Abort during the long gap after entry 0
      clear_log();
      start_a = 1'b1; @(negedge clk); start_a = 1'b0;
      n = 0;
      while (acc_idx.size() == 0 && n < 20) begin @(negedge clk); n++; end
      chk("abg_accept_timeout", n < 20, 1);
      repeat (30) @(negedge clk);
      chk("abg_in_gap_busy", busy_a, 1); chk("abg_in_gap_idx", idx_a, 1);
      abort_a = 1'b1; @(negedge clk); abort_a = 1'b0;
      chk("abg_idle", busy_a, 0);
      repeat (20) @(negedge clk);
      chk("abg_no_new_cmd", acc_idx.size(), 1);

      // Instance B: no auto-start, reset mid-gap, start+abort
      rst_b = 1'b0;
      repeat (5) @(negedge clk);
      chk("b_no_autostart_busy", busy_b, 0); chk("b_no_autostart_acc", b_acc, 0);
      start_b = 1'b1; @(negedge clk); start_b = 1'b0;
      n = 0;
      while (b_acc < 10 && n < 3000) begin @(negedge clk); n++; end
      chk("b_reach9", n < 3000, 1);
      repeat (5) @(negedge clk);
      chk("b_gap_busy", busy_b, 1); chk("b_gap_valid", valid_b, 0); chk("b_gap_idx", idx_b, 10);
      rst_b = 1'b1; @(negedge clk); rst_b = 1'b0;
      chk("b_rst_valid", valid_b, 0); chk("b_rst_busy", busy_b, 0); chk("b_rst_done", dn_b, 0);
      chk("b_rst_err", err_b, 0); chk("b_rst_idx", idx_b, 0); chk("b_rst_data", data_b, 0);
      chk("b_rst_addr", addr_b, 0);
      acc0 = b_acc;
      repeat (40) @(negedge clk);
      chk("b_idle_no_cmd", b_acc, acc0); chk("b_idle_busy", busy_b, 0);
      start_b = 1'b1; abort_b = 1'b1; @(negedge clk); start_b = 1'b0; abort_b = 1'b0;
      repeat (20) @(negedge clk);
      chk("b_start_abort_busy", busy_b, 0); chk("b_start_abort_acc", b_acc, acc0);
      start_b = 1'b1; @(negedge clk); start_b = 1'b0;
      chk("b_start_busy", busy_b, 1);
      n = 0;
      while (b_acc == acc0 && n < 10) begin @(negedge clk); n++; end
      chk("b_start_accept", n < 10, 1);
      chk("b_first_data", b_last, TBL[0]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
